// File: rtl/i2s_tx_arbiter.sv
// i2s_tx_arbiter: round-robin owner of the I2S TX path, one buffered stereo word per frame.
// Define I2S_ARB_LOOPBACK_EN to send captured RX audio as the idle word.
`ifndef DATA_BIT
`define DATA_BIT 24
`endif

module i2s_tx_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_frame_tick,
    input  logic [NUM_SRC-1:0]            i_req,
    output logic [NUM_SRC-1:0]            o_gnt,
    input  logic [NUM_SRC*`DATA_BIT-1:0]  i_src_l,
    input  logic [NUM_SRC*`DATA_BIT-1:0]  i_src_r,
    input  logic [NUM_SRC-1:0]            i_src_valid,
    output logic [NUM_SRC-1:0]            o_src_ready,
    input  logic [`DATA_BIT-1:0]          i_rx_l,
    input  logic [`DATA_BIT-1:0]          i_rx_r,
    output logic [`DATA_BIT-1:0]          o_tx_l,
    output logic [`DATA_BIT-1:0]          o_tx_r,
    output logic                          o_tx_valid,
    output logic                          o_underrun,
    output logic [2:0]                    o_active_id
);
    localparam int DW = `DATA_BIT;
    localparam logic [2:0] LAST = 3'(NUM_SRC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANTED, S_DRAIN} state_t;
    state_t r_state, w_next;

    logic [2:0]    r_gnt_id, r_rr_ptr, w_pick;
    logic [7:0]    r_miss;
    logic          r_buf_full, r_tx_valid, r_underrun;
    logic [DW-1:0] r_buf_l, r_buf_r, r_tx_l, r_tx_r;
    logic [DW-1:0] w_src_l [8];
    logic [DW-1:0] w_src_r [8];
    logic [7:0]    w_req, w_valid, w_onehot;
    logic          w_any, w_own, w_xfer, w_miss_hit, w_revoke, w_leave;
    logic [DW-1:0] w_idle_l, w_idle_r, w_word_l, w_word_r;

    // Sources are widened to 8 slots so a 3-bit id can index them directly.
    genvar g;
    for (g = 0; g < 8; g++) begin : g_src
        if (g < NUM_SRC) begin : g_on
            assign w_src_l[g] = i_src_l[g*DW +: DW];
            assign w_src_r[g] = i_src_r[g*DW +: DW];
        end else begin : g_off
            assign w_src_l[g] = '0;
            assign w_src_r[g] = '0;
        end
    end

    assign w_req      = 8'(i_req);
    assign w_valid    = 8'(i_src_valid);
    assign w_any      = |i_req;
    assign w_own      = (r_state == S_GRANTED) || (r_state == S_DRAIN);
    assign w_onehot   = 8'd1 << r_gnt_id;
    assign w_xfer     = (r_state == S_GRANTED) && !r_buf_full && w_valid[r_gnt_id];
    assign w_miss_hit = 9'(r_miss) + 9'd1 >= 9'(IDLE_TIMEOUT);
    assign w_revoke   = (r_state == S_GRANTED) && i_frame_tick && !r_buf_full && w_miss_hit;
    assign w_leave    = w_own && (w_next == S_IDLE);

    // Scanning backwards leaves the first requester at or after rr_ptr as the winner.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (w_req[3'((int'(r_rr_ptr) + k) % NUM_SRC)]) w_pick = 3'((int'(r_rr_ptr) + k) % NUM_SRC);
    end

    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = w_any ? S_ARB : S_IDLE;
            S_ARB:     w_next = w_any ? S_GRANTED : S_IDLE;
            S_GRANTED: w_next = w_revoke ? S_IDLE : (w_req[r_gnt_id] ? S_GRANTED : S_DRAIN);
            S_DRAIN:   w_next = i_frame_tick ? S_IDLE : S_DRAIN;
        endcase
    end

    always_comb begin
        o_gnt       = w_own ? w_onehot[NUM_SRC-1:0] : '0;
        o_src_ready = (r_state == S_GRANTED && !r_buf_full) ? w_onehot[NUM_SRC-1:0] : '0;
        o_active_id = w_own ? r_gnt_id : 3'd0;
    end

`ifdef I2S_ARB_LOOPBACK_EN
    assign w_idle_l = i_rx_l;
    assign w_idle_r = i_rx_r;
`else
    logic w_unused_rx;
    assign w_unused_rx = ^{i_rx_l, i_rx_r};
    assign w_idle_l    = '0;
    assign w_idle_r    = '0;
`endif

    assign w_word_l = w_own ? (r_buf_full ? r_buf_l : '0) : w_idle_l;
    assign w_word_r = w_own ? (r_buf_full ? r_buf_r : '0) : w_idle_r;

    // A sample accepted on the revoke cycle is dropped with the grant.
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            r_gnt_id   <= '0;
            r_rr_ptr   <= '0;
            r_miss     <= '0;
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
            r_tx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_tx_l     <= '0;
            r_tx_r     <= '0;
        end else begin
            if (r_state == S_ARB) begin
                r_gnt_id <= w_pick;
                r_miss   <= '0;
            end else if (i_frame_tick && r_state == S_GRANTED && !r_buf_full)
                r_miss <= (r_miss == 8'hFF) ? r_miss : r_miss + 8'd1;
            else if (i_frame_tick && w_own && r_buf_full)
                r_miss <= '0;
            if (w_leave) r_rr_ptr <= (r_gnt_id == LAST) ? 3'd0 : r_gnt_id + 3'd1;
            r_buf_full <= (w_next == S_IDLE) ? 1'b0 : w_xfer ? 1'b1 : (i_frame_tick && w_own) ? 1'b0 : r_buf_full;
            if (w_xfer) begin
                r_buf_l <= w_src_l[r_gnt_id];
                r_buf_r <= w_src_r[r_gnt_id];
            end
            r_tx_valid <= i_frame_tick;
            r_underrun <= i_frame_tick && (r_state == S_GRANTED) && !r_buf_full;
            if (i_frame_tick) begin
                r_tx_l <= w_word_l;
                r_tx_r <= w_word_r;
            end
        end

    assign o_tx_l     = r_tx_l;
    assign o_tx_r     = r_tx_r;
    assign o_tx_valid = r_tx_valid;
    assign o_underrun = r_underrun;
endmodule

// File: tb/tb_i2s_tx_arbiter.sv
// tb_i2s_tx_arbiter: randomized request/sample streams checked against a behavioural arbiter model.
`ifndef DATA_BIT
`define DATA_BIT 24
`endif

module tb_i2s_tx_arbiter;
    localparam int N = 4, T = 8, DW = `DATA_BIT;

    logic            clk = 1'b0, reset_n = 1'b0, tick = 1'b0;
    logic [N-1:0]    req = '0, valid = '0, gnt, ready;
    logic [N*DW-1:0] src_l = '0, src_r = '0;
    logic [DW-1:0]   rx_l = '0, rx_r = '0, tx_l, tx_r;
    logic            tx_valid, underrun;
    logic [2:0]      active_id;

    int n_run = 0, n_fail = 0, gap = 20;

    // Model: current owner (-1 when none), a pending arbitration slot, a release flag and a 1-deep sample queue.
    int owner, misses, next_start;
    bit arbitrating, releasing, e_valid, e_under;
    logic [2*DW-1:0] held[$];
    logic [DW-1:0] e_l, e_r;

    int ph_len[6]   = '{150, 500, 1500, 800, 1500, 1000};
    int ph_churn[6] = '{0, 0, 200, 0, 80, 150};
    int ph_vprob[6] = '{0, 100, 40, 0, 15, 70};
    int ph_mask[6]  = '{0, 4, 15, 15, 9, 15};

    i2s_tx_arbiter #(.NUM_SRC(N), .IDLE_TIMEOUT(T)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_frame_tick(tick), .i_req(req), .o_gnt(gnt),
        .i_src_l(src_l), .i_src_r(src_r), .i_src_valid(valid), .o_src_ready(ready),
        .i_rx_l(rx_l), .i_rx_r(rx_r), .o_tx_l(tx_l), .o_tx_r(tx_r), .o_tx_valid(tx_valid),
        .o_underrun(underrun), .o_active_id(active_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; misses = 0; next_start = 0;
        arbitrating = 0; releasing = 0; held.delete();
        e_l = '0; e_r = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", tx_valid, 0);
        check("rst_under", underrun, 0);
        check("rst_gnt", gnt, 0);
        check("rst_ready", ready, 0);
        check("rst_id", active_id, 0);
        check("rst_tx", {tx_l, tx_r}, 0);
    endtask

    task automatic model_step();
        logic [2*DW-1:0] w;
        bit accept, ended;
        accept = owner >= 0 && !releasing && held.size() == 0 && valid[owner];
        e_valid = tick;
        e_under = 0;
        if (tick) begin
            if (owner >= 0) begin
                if (held.size() > 0) begin
                    w = held.pop_front();
                    e_l = w[2*DW-1:DW]; e_r = w[DW-1:0]; misses = 0;
                end else begin
                    e_l = '0; e_r = '0;
                    if (!releasing) begin e_under = 1; misses++; end
                end
            end else begin
`ifdef I2S_ARB_LOOPBACK_EN
                e_l = rx_l; e_r = rx_r;
`else
                e_l = '0; e_r = '0;
`endif
            end
        end
        if (accept) held.push_back({src_l[owner*DW +: DW], src_r[owner*DW +: DW]});
        ended = 0;
        if (owner < 0) begin
            if (arbitrating) begin
                arbitrating = 0;
                for (int k = 0; k < N; k++)
                    if (owner < 0 && req[(next_start + k) % N]) owner = (next_start + k) % N;
                misses = 0;
            end else arbitrating = |req;
        end else if (!releasing) begin
            if (e_under && misses >= T) ended = 1;
            else if (!req[owner]) releasing = 1;
        end else if (tick) ended = 1;
        if (ended) begin
            next_start = (owner + 1) % N;
            owner = -1; releasing = 0; held.delete();
        end
    endtask

    task automatic step(input int churn, input int vprob, input int mask);
        @(negedge clk);
        tick = (gap == 0);
        gap = tick ? int'($urandom_range(15, 23)) : gap - 1;
        for (int k = 0; k < N; k++) begin
            if (churn == 0) req[k] = mask[k];
            else if ($urandom_range(0, churn - 1) == 0) req[k] = ~req[k] & mask[k];
            valid[k] = ($urandom_range(0, 99) < vprob);
            src_l[k*DW +: DW] = DW'($urandom);
            src_r[k*DW +: DW] = DW'($urandom);
        end
        rx_l = DW'($urandom); rx_r = DW'($urandom);
        #1;
        check("gnt", gnt, owner >= 0 ? (1 << owner) : 0);
        check("ready", ready, (owner >= 0 && !releasing && held.size() == 0) ? (1 << owner) : 0);
        check("active_id", active_id, owner >= 0 ? owner : 0);
        model_step();
        @(posedge clk);
        #1;
        check("tx_valid", tx_valid, e_valid);
        check("underrun", underrun, e_under);
        if (e_valid) begin
            check("tx_l", tx_l, e_l);
            check("tx_r", tx_r, e_r);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        tick = 0; req = '0; valid = '0;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        gap = 20;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        for (int p = 0; p < 6; p++) begin
            if (p == 4) mid_reset();
            for (int c = 0; c < ph_len[p]; c++) step(ph_churn[p], ph_vprob[p], ph_mask[p]);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
